// File: rtl/rx_sink.sv
// rx_sink: valid/ready receive FIFO with a registered pop port; RX_STATS_EN adds rx_cnt_o and stall_o.
// Latency: an accepted word is poppable next cycle; data_o/data_valid_o appear one cycle after rd_en.
// Backpressure: registered ready_o drops the cycle the FIFO fills and rises the cycle after a pop frees space.
module rx_sink #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_i,
    input  logic [DATA_W-1:0]      data_i,
    output logic                   ready_o,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      data_o,
    output logic                   data_valid_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
`ifdef RX_STATS_EN
    ,
    output logic [15:0]            rx_cnt_o,
    output logic                   stall_o
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  next_count;
    logic              push;
    logic              pop;

    // Pop qualifies on the registered count, so a push into an empty FIFO is never bypassed.
    assign push    = valid_i && ready_o;
    assign pop     = rd_en && !empty_o;
    assign empty_o = (count == '0);
    assign full_o  = (count == DEPTH_C);
    assign count_o = count;

    always_comb begin
        next_count = count;
        if (push && !pop) begin
            next_count = count + CNT_ONE;
        end else if (pop && !push) begin
            next_count = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            state        <= EMPTY;
            ready_o      <= 1'b0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
        end else begin
            count        <= next_count;
            ready_o      <= (next_count < DEPTH_C);
            data_valid_o <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                data_o <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case (state)
                EMPTY: begin
                    if (push) begin
                        state <= PARTIAL;
                    end
                end
                PARTIAL: begin
                    if (push && !pop && count == DEPTH_C - CNT_ONE) begin
                        state <= FULL;
                    end else if (pop && !push && count == CNT_ONE) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state <= PARTIAL;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef RX_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_cnt_o <= '0;
            stall_o  <= 1'b0;
        end else begin
            if (push && rx_cnt_o != 16'hFFFF) begin
                rx_cnt_o <= rx_cnt_o + 16'd1;
            end
            stall_o <= valid_i && !ready_o;
        end
    end
`endif

endmodule
